// File: rtl/approx_mult_controller.sv
// approx_mult_controller: sequencing FSM for the leading-one approximate multiplier datapath.
// Optional feature macro: ZERO_GUARD_EN (adds a shift guard that flags zero operands on `zero`).
module approx_mult_controller (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic DoneA,
    input  logic DoneB,
    input  logic downDone,
    output logic loadA,
    output logic loadB,
    output logic shlA,
    output logic shlB,
    output logic rst5,
    output logic cntU,
    output logic cntD,
    output logic loadOut,
    output logic shrOut,
    output logic ready,
    output logic done,
    output logic zero
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ALIGN_A = 3'd2,
        ALIGN_B = 3'd3,
        MULT    = 3'd4,
        NORM    = 3'd5,
        FIN     = 3'd6
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   guard_hit_s;

`ifdef ZERO_GUARD_EN
    logic [3:0] guard_q;
    logic [3:0] guard_d;
    logic       zero_q;
    logic       zero_d;

    assign guard_hit_s = (guard_q == 4'd15);
    assign zero        = zero_q;

    // Guard restarts on entry to each align state and counts the shifts taken there
    always_comb begin
        guard_d = guard_q;
        zero_d  = zero_q;
        if (shlA || shlB) begin
            guard_d = guard_q + 4'd1;
        end else if ((state_q == LOAD) || ((state_q == ALIGN_A) && DoneA)) begin
            guard_d = 4'd0;
        end else begin
            guard_d = guard_q;
        end
        if ((state_q == IDLE) && start) begin
            zero_d = 1'b0;
        end else if ((((state_q == ALIGN_A) && !DoneA) || ((state_q == ALIGN_B) && !DoneB)) && guard_hit_s) begin
            zero_d = 1'b1;
        end else begin
            zero_d = zero_q;
        end
    end

    // Guard and zero-flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            guard_q <= 4'd0;
            zero_q  <= 1'b0;
        end else begin
            guard_q <= guard_d;
            zero_q  <= zero_d;
        end
    end
`else
    assign guard_hit_s = 1'b0;
    assign zero        = 1'b0;
`endif

    // Next state and control strobes; strobes depend on live status so shifts stop the cycle alignment is reached
    always_comb begin
        state_d = state_q;
        loadA   = 1'b0;
        loadB   = 1'b0;
        shlA    = 1'b0;
        shlB    = 1'b0;
        rst5    = 1'b0;
        cntU    = 1'b0;
        cntD    = 1'b0;
        loadOut = 1'b0;
        shrOut  = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                loadA   = 1'b1;
                loadB   = 1'b1;
                rst5    = 1'b1;
                state_d = ALIGN_A;
            end
            ALIGN_A: begin
                if (DoneA) begin
                    state_d = ALIGN_B;
                end else if (guard_hit_s) begin
                    state_d = FIN;
                end else begin
                    shlA = 1'b1;
                    cntU = 1'b1;
                end
            end
            ALIGN_B: begin
                if (DoneB) begin
                    state_d = MULT;
                end else if (guard_hit_s) begin
                    state_d = FIN;
                end else begin
                    shlB = 1'b1;
                    cntU = 1'b1;
                end
            end
            MULT: begin
                loadOut = 1'b1;
                state_d = NORM;
            end
            NORM: begin
                if (downDone) begin
                    state_d = FIN;
                end else begin
                    shrOut = 1'b1;
                    cntD   = 1'b1;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
